spi_rx_slave: RTL
=================

# spi_rx_slave

Receive-side SPI slave that captures the serial frames produced by the team's 12-bit SPI master (active-low `cs`, LSB-first `mosi`). It deserialises each frame into a parallel word, detects short frames, and holds the result in a one-entry output buffer with a valid/ready handshake. It sits directly downstream of the master on the same `sclk` domain and feeds the register or FIFO logic that consumes received data.

## Interface
- `DATA_W`, default 12: frame length in bits and width of `dout`.
- `CNT_W`, default 4: bit-counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- `sclk`  in  1  clock; every action occurs on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting low clears all state immediately; release is synchronous to `sclk`.
- `cs`  in  1  chip select, active low, driven by the master.
- `mosi`  in  1  serial data, LSB first.
- `dout`  out  DATA_W  received word; valid while `dout_valid`=1.
- `dout_valid`  out  1  the buffer holds an unconsumed word.
- `dout_ready`  in  1  consumer accepts the word.
- `frame_err`  out  1  one-cycle pulse: `cs` went high before DATA_W bits were received.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped because the buffer was full.

## Operation
- **Reset values.** State=IDLE, bit count=0, shift register=0, `dout`=0, `dout_valid`=0, `frame_err`=0, `overrun`=0.
- **IDLE.**
  - `cs`=1: remain in IDLE.
  - `cs`=0 sampled: go to SETUP. This edge's `mosi` is discarded, because the master drives bit 0 one edge after it lowers `cs`.
- **SETUP.**
  - `cs`=0: sample `mosi` into bit 0, set count=1, go to SHIFT.
  - `cs`=1: pulse `frame_err` and go to IDLE.
- **SHIFT.**
  - `cs`=0: sample `mosi` into bit[count] and increment count.
  - When the sample lands in bit DATA_W-1, the word is complete. Commit it (see below) and go to TAIL.
  - `cs`=1 before completion: pulse `frame_err`, discard partial data, reset count to 0, go to IDLE.
- **TAIL.**
  - `cs`=0: extra edges are ignored, with no error raised.
  - `cs`=1: go to IDLE. The next frame requires a fresh high-to-low transition on `cs`.
- **Commit** (on the edge that samples bit DATA_W-1):
  - Buffer empty, or `dout_ready`=1 on the same edge: load `dout` and set `dout_valid`=1.
  - Buffer full and `dout_ready`=0: keep the old word, drop the new one, and pulse `overrun`.
- **Handshake.**
  - A transfer occurs on any edge with `dout_valid`=1 and `dout_ready`=1.
  - On a transfer with no simultaneous commit, `dout_valid` clears. `dout` holds its last value.
  - `dout_ready` has no effect when `dout_valid`=0.
  - `dout` and `dout_valid` never change while `dout_valid`=1 and `dout_ready`=0.
- **Bit order.** The first sampled bit maps to `dout[0]`; the last maps to `dout[DATA_W-1]`.
- **Count width.** The count never exceeds DATA_W and never wraps.

## Timing
- The master lowers `cs` at edge E0. The slave sees `cs` low at E1 (SETUP) and samples bits 0..11 at edges E2..E13.
- `dout_valid` is high after E13. Latency is 13 edges from first `cs`-low sample to valid.
- Back-to-back frames are supported whenever `cs` is high for at least one edge between them. Each idle edge with `cs` high costs at least one edge.
- `frame_err` and `overrun` are registered and stay high for exactly one cycle.
- Reset asserted mid-frame: all outputs return to their reset values immediately. After release the slave waits in IDLE; if `cs` is still low, that frame is treated as a new frame starting at the next sampled edge.
- Simultaneous commit and transfer: the new word replaces the old one, `dout_valid` stays 1, and no overrun is raised.
- `cs`=1 on the edge that would sample bit DATA_W-1: this counts as a short frame and raises `frame_err`.

## Test plan
- **Single frame.** Reset, then send 0xA5C LSB-first via the master with `dout_ready`=1 -> `dout`=0xA5C and `dout_valid` high for one cycle, 13 edges after the first `cs`-low sample.
- **Back-pressure and overrun.** `dout_ready`=0; send 0x123 then 0x456 -> `dout`=0x123 is held and `overrun` pulses once when 0x456 completes. Then assert `dout_ready` -> `dout_valid` drops.
- **Short frame.** Raise `cs` after 5 bits -> `frame_err` pulses once and `dout_valid` stays 0. The following full frame 0xFFF is received correctly.
- **Commit with concurrent ready.** Buffer holds 0x001; assert `dout_ready` on the commit edge of 0x800 -> `dout`=0x800, `dout_valid` stays 1, no `overrun`.
- **Reset mid-frame.** Pull `reset` low after 6 bits -> all outputs are 0 asynchronously. Release, then send a clean 0x3C3 frame -> `dout`=0x3C3.
- **Long cs.** Hold `cs` low for 4 extra edges after 0x7E1 -> one word 0x7E1 is received, with no error and no second commit.

Source files
------------

// File: rtl/spi_rx_slave.sv
// Receive-side SPI slave: deserialises LSB-first frames framed by an active-low cs
// into a one-entry valid/ready output buffer, flagging short frames and dropped words.
module spi_rx_slave #(
   parameter int DATA_W = 12,
   parameter int CNT_W  = 4
) (
   input  logic              sclk,
   input  logic              reset,
   input  logic              cs,
   input  logic              mosi,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              frame_err,
   output logic              overrun
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      TAIL
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t              state;
   state_t              state_next;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    count_next;
   logic [DATA_W-1:0]   shreg;
   logic [DATA_W-1:0]   shreg_next;
   logic [DATA_W-1:0]   word;
   logic                commit;
   logic                load;
   logic                frame_err_next;
   logic                overrun_next;
   logic                dout_valid_next;

   always_ff @(posedge sclk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         count      <= '0;
         shreg      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_next;
         count      <= count_next;
         shreg      <= shreg_next;
         dout_valid <= dout_valid_next;
         frame_err  <= frame_err_next;
         overrun    <= overrun_next;
         if (load) begin
            dout <= word;
         end
      end
   end

   // The first cs-low edge only arms the frame; bit 0 arrives one edge later.
   always_comb begin
      state_next     = state;
      count_next     = count;
      shreg_next     = shreg;
      commit         = 1'b0;
      frame_err_next = 1'b0;
      word           = shreg | (DATA_W'(mosi) << count);

      case (state)
         IDLE: begin
            if (!cs) begin
               state_next = SETUP;
            end
         end
         SETUP: begin
            if (!cs) begin
               shreg_next = DATA_W'(mosi);
               count_next = CNT_W'(1);
               state_next = SHIFT;
            end else begin
               frame_err_next = 1'b1;
               state_next     = IDLE;
            end
         end
         SHIFT: begin
            if (!cs) begin
               shreg_next = word;
               count_next = count + CNT_W'(1);
               if (count == LAST_BIT) begin
                  commit     = 1'b1;
                  state_next = TAIL;
               end
            end else begin
               frame_err_next = 1'b1;
               shreg_next     = '0;
               count_next     = '0;
               state_next     = IDLE;
            end
         end
         TAIL: begin
            if (cs) begin
               count_next = '0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // A commit coinciding with a transfer replaces the word instead of overrunning.
   always_comb begin
      load            = commit && (!dout_valid || dout_ready);
      overrun_next    = commit && dout_valid && !dout_ready;
      dout_valid_next = dout_valid;
      if (load) begin
         dout_valid_next = 1'b1;
      end else if (dout_valid && dout_ready) begin
         dout_valid_next = 1'b0;
      end
   end

endmodule
